// File: rtl/mac_cfg_seq.sv
// Avalon-MM register configuration sequencer: walks an external op table after a power-up delay
// or a start pulse. Define MAC_CFG_READBACK_EN to verify every write with a readback.
module mac_cfg_seq #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned N_ENTRY   = 16,
    parameter int unsigned START_DLY = 65520,
    parameter int unsigned TIMEOUT   = 1023,
    parameter int unsigned POLL_MAX  = 255,
    localparam int unsigned IDX_W    = $clog2(N_ENTRY)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [IDX_W-1:0]  tbl_idx,
    input  logic [2:0]        tbl_op,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic [DATA_W-1:0] tbl_mask,
    input  logic [47:0]       mac_addr,
    output logic [ADDR_W-1:0] address,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic              read,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IDX_W-1:0]  err_idx,
    output logic [1:0]        err_code
);

    localparam int unsigned DLY_W     = (START_DLY > 1) ? $clog2(START_DLY) : 1;
    localparam int unsigned DLY_LAST  = (START_DLY > 0) ? START_DLY - 1 : 0;
    localparam int unsigned TO_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned PC_W      = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
    localparam int unsigned POLL_LAST = (POLL_MAX > 0) ? POLL_MAX - 1 : 0;

    localparam logic [2:0] OpEnd   = 3'd0;
    localparam logic [2:0] OpWrite = 3'd1;
    localparam logic [2:0] OpRdChk = 3'd2;
    localparam logic [2:0] OpPoll  = 3'd3;
    localparam logic [2:0] OpMacLo = 3'd4;
    localparam logic [2:0] OpMacHi = 3'd5;

    typedef enum logic [2:0] {
        StWaitDly, StFetch, StWr, StRd, StCheck, StDone, StErr
    } state_e;

    state_e            state_q, state_d;
    logic [DLY_W-1:0]  dly_q;
    logic [TO_W-1:0]   to_q;
    logic [PC_W-1:0]   poll_q;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] exp_q, mask_q, rdata_q, wdata_sel;
    logic [1:0]        code_d;
    logic              strobe, acc_done, tmo_hit, match, last, restart;

    assign strobe   = write | read;
    assign acc_done = strobe & ~waitrequest;
    assign tmo_hit  = strobe & waitrequest & (to_q == TO_W'(TIMEOUT));
    assign match    = ((rdata_q ^ exp_q) & mask_q) == '0;
    assign last     = tbl_idx == IDX_W'(N_ENTRY - 1);
    assign restart  = start & (state_q == StDone || state_q == StErr);

    always_comb begin
        wdata_sel = tbl_data;
        if (tbl_op == OpMacLo) begin
            wdata_sel = DATA_W'(mac_addr[31:0]);
        end else if (tbl_op == OpMacHi) begin
            wdata_sel = DATA_W'(mac_addr[47:32]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWaitDly;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = 2'b00;
        unique case (state_q)
            StWaitDly: if (dly_q == DLY_W'(DLY_LAST)) state_d = StFetch;
            StFetch: begin
                case (tbl_op)
                    OpWrite, OpMacLo, OpMacHi: state_d = StWr;
                    OpRdChk, OpPoll:           state_d = StRd;
                    default:                   state_d = StDone;
                endcase
            end
            StWr: begin
                if (tmo_hit) begin
                    state_d = StErr;
                    code_d  = 2'b10;
                end else if (acc_done) begin
`ifdef MAC_CFG_READBACK_EN
                    state_d = StRd;
`else
                    state_d = last ? StDone : StFetch;
`endif
                end
            end
            StRd: begin
                if (tmo_hit) begin
                    state_d = StErr;
                    code_d  = 2'b10;
                end else if (acc_done) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (match) begin
                    state_d = last ? StDone : StFetch;
                end else if (op_q == OpPoll && poll_q != PC_W'(POLL_LAST)) begin
                    state_d = StRd;
                end else begin
                    state_d = StErr;
                    code_d  = (op_q == OpPoll) ? 2'b11 : 2'b01;
                end
            end
            StDone, StErr: if (start) state_d = StFetch;
            default: state_d = StWaitDly;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        unique case (state_q)
            StFetch, StWr, StRd, StCheck: busy = 1'b1;
            StDone:                       done = 1'b1;
            StErr:                        err  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q     <= '0;
            to_q      <= '0;
            poll_q    <= '0;
            tbl_idx   <= '0;
            op_q      <= OpEnd;
            exp_q     <= '0;
            mask_q    <= '0;
            rdata_q   <= '0;
            address   <= '0;
            writedata <= '0;
            write     <= 1'b0;
            read      <= 1'b0;
            err_idx   <= '0;
            err_code  <= 2'b00;
        end else begin
            if (state_q == StWaitDly) dly_q <= dly_q + DLY_W'(1);
            // exp_q doubles as the readback reference, which is the write value for write ops.
            if (state_q == StFetch) begin
                op_q      <= tbl_op;
                address   <= tbl_addr;
                writedata <= wdata_sel;
                exp_q     <= wdata_sel;
                mask_q    <= tbl_mask;
                poll_q    <= '0;
            end
            if (state_q == StWr || state_q == StRd) begin
                if (!strobe) begin
                    write <= (state_q == StWr);
                    read  <= (state_q == StRd);
                    to_q  <= '0;
                end else if (!waitrequest || tmo_hit) begin
                    write <= 1'b0;
                    read  <= 1'b0;
                end else begin
                    to_q <= to_q + TO_W'(1);
                end
            end
            if (acc_done && read) rdata_q <= readdata;
            if (state_q == StCheck && !match) poll_q <= poll_q + PC_W'(1);
            if (restart) begin
                tbl_idx  <= '0;
                err_idx  <= '0;
                err_code <= 2'b00;
            end else if (state_d == StFetch && (state_q == StWr || state_q == StCheck)) begin
                tbl_idx <= tbl_idx + IDX_W'(1);
            end
            if (state_d == StErr && state_q != StErr) begin
                err_idx  <= tbl_idx;
                err_code <= code_d;
            end
        end
    end

endmodule

// File: tb/tb_mac_cfg_seq.sv
// Directed self-checking bench for mac_cfg_seq (default build, readback disabled).
module tb_mac_cfg_seq;
    localparam int unsigned N_ENTRY = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  tbl_idx;
    logic [2:0]  tbl_op;
    logic [7:0]  tbl_addr;
    logic [31:0] tbl_data, tbl_mask;
    logic [47:0] mac_addr = '0;
    logic [7:0]  address;
    logic        write, read, busy, done, err;
    logic [31:0] writedata, readdata;
    logic        waitrequest = 1'b0;
    logic [3:0]  err_idx;
    logic [1:0]  err_code;

    logic [2:0]  t_op   [N_ENTRY];
    logic [7:0]  t_addr [N_ENTRY];
    logic [31:0] t_data [N_ENTRY];
    logic [31:0] t_mask [N_ENTRY];

    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0, wr_cnt = 0, rd_base = 0, wr_base = 0;
    logic [7:0]  wr_addr [64];
    logic [31:0] wr_data [64];
    logic [31:0] rd_val = '0;
    logic        rd_mode = 1'b0;

    assign tbl_op   = t_op[tbl_idx];
    assign tbl_addr = t_addr[tbl_idx];
    assign tbl_data = t_data[tbl_idx];
    assign tbl_mask = t_mask[tbl_idx];
    // Poll mode: bit0 reads as 1 from the third read of the scenario on.
    assign readdata = rd_mode ? ((rd_cnt - rd_base >= 2) ? 32'h1 : 32'h0) : rd_val;

    mac_cfg_seq #(
        .ADDR_W(8), .DATA_W(32), .N_ENTRY(N_ENTRY), .START_DLY(16), .TIMEOUT(1023), .POLL_MAX(255)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tbl_idx(tbl_idx), .tbl_op(tbl_op),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_mask(tbl_mask), .mac_addr(mac_addr),
        .address(address), .write(write), .writedata(writedata), .read(read),
        .readdata(readdata), .waitrequest(waitrequest), .busy(busy), .done(done), .err(err),
        .err_idx(err_idx), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && !waitrequest) begin
            if (write) begin
                wr_addr[wr_cnt & 63] <= address;
                wr_data[wr_cnt & 63] <= writedata;
                wr_cnt <= wr_cnt + 1;
            end
            if (read) rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic clear_tbl();
        for (int i = 0; i < N_ENTRY; i++) begin
            t_op[i] = 3'd0; t_addr[i] = '0; t_data[i] = '0; t_mask[i] = '0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (done || err) break;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({write, read, busy, done, err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {write, read, busy, done, err});
        end
        checks++;
        if ({tbl_idx, err_idx, err_code} !== 10'h0) begin
            errors++; $display("FAIL reset_idx: got %h expected 000", {tbl_idx, err_idx, err_code});
        end
        checks++;
        if ({address, writedata} !== 40'h0) begin
            errors++; $display("FAIL reset_bus: got %h expected 0", {address, writedata});
        end
    endtask

    task automatic test_first_write();
        clear_tbl();
        t_op[0] = 3'd1; t_addr[0] = 8'h02; t_data[0] = 32'h0400_003B;
        wr_base = wr_cnt;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            if (c == 15) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL busy_c15: got %b expected 0", busy); end
            end
            if (c == 16) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL busy_c16: got %b expected 1", busy); end
            end
            if (c == 17) begin
                checks++;
                if (write !== 1'b0) begin errors++; $display("FAIL write_c17: got %b expected 0", write); end
            end
        end
        checks++;
        if ({write, address, writedata} !== {1'b1, 8'h02, 32'h0400_003B}) begin
            errors++; $display("FAIL write_c18: got %b %h %h expected 1 02 0400003b", write, address, writedata);
        end
        wait_end(50);
        checks++;
        if ({done, err} !== 2'b10 || wr_cnt - wr_base != 1) begin
            errors++; $display("FAIL first_done: got done=%b err=%b writes=%0d expected 1 0 1", done, err, wr_cnt - wr_base);
        end
    endtask

    task automatic test_read_check();
        clear_tbl();
        t_op[0] = 3'd2; t_addr[0] = 8'h01; t_data[0] = 32'hA5A5_A5A5; t_mask[0] = 32'hFFFF_FFFF;
        rd_mode = 1'b0; rd_val = 32'hA5A5_A5A4;
        pulse_start();
        wait_end(50);
        checks++;
        if ({err, err_code, err_idx, done} !== {1'b1, 2'b01, 4'd0, 1'b0}) begin
            errors++; $display("FAIL rdchk_mismatch: got err=%b code=%b idx=%0d done=%b expected 1 01 0 0", err, err_code, err_idx, done);
        end
        // Entry 0 matches under a mask that hides bit0; entry 1 does not.
        t_mask[0] = 32'hFFFF_FFFE;
        t_op[1] = 3'd2; t_addr[1] = 8'h01; t_data[1] = 32'hA5A5_A5A5; t_mask[1] = 32'h0000_0001;
        pulse_start();
        checks++;
        if ({err, busy} !== 2'b01) begin
            errors++; $display("FAIL restart_clears_err: got err=%b busy=%b expected 0 1", err, busy);
        end
        wait_end(50);
        checks++;
        if ({err, err_code, err_idx} !== {1'b1, 2'b01, 4'd1}) begin
            errors++; $display("FAIL rdchk_masked: got err=%b code=%b idx=%0d expected 1 01 1", err, err_code, err_idx);
        end
    endtask

    task automatic test_poll();
        clear_tbl();
        t_op[0] = 3'd3; t_addr[0] = 8'h03; t_data[0] = 32'h1; t_mask[0] = 32'h1;
        rd_mode = 1'b1; rd_base = rd_cnt;
        pulse_start();
        wait_end(100);
        checks++;
        if ({done, err} !== 2'b10 || rd_cnt - rd_base != 3) begin
            errors++; $display("FAIL poll_ok: got done=%b err=%b reads=%0d expected 1 0 3", done, err, rd_cnt - rd_base);
        end
        rd_mode = 1'b0; rd_val = 32'h0; rd_base = rd_cnt;
        pulse_start();
        wait_end(3000);
        checks++;
        if ({err, err_code} !== 3'b111 || rd_cnt - rd_base != 255) begin
            errors++; $display("FAIL poll_stuck: got err=%b code=%b reads=%0d expected 1 11 255", err, err_code, rd_cnt - rd_base);
        end
    endtask

    task automatic test_timeout();
        int hi;
        hi = 0;
        clear_tbl();
        t_op[0] = 3'd1; t_addr[0] = 8'h05; t_data[0] = 32'hDEAD_BEEF;
        waitrequest = 1'b1;
        pulse_start();
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk); #1;
            if (write) hi++;
        end
        checks++;
        if ({err, err_code, write, read} !== 5'b11000 || hi != 1024) begin
            errors++; $display("FAIL timeout: got err=%b code=%b wr=%b rd=%b high=%0d expected 1 10 0 0 1024", err, err_code, write, read, hi);
        end
        waitrequest = 1'b0;
    endtask

    task automatic test_mac();
        clear_tbl();
        mac_addr = 48'h5544_3322_1100;
        t_op[0] = 3'd4; t_addr[0] = 8'h10;
        t_op[1] = 3'd5; t_addr[1] = 8'h11;
        wr_base = wr_cnt;
        pulse_start();
        @(negedge clk) start = 1'b1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_during_start: got %b expected 1", busy); end
        @(negedge clk) start = 1'b0;
        wait_end(50);
        checks++;
        if (done !== 1'b1 || wr_cnt - wr_base != 2) begin
            errors++; $display("FAIL mac_count: got done=%b writes=%0d expected 1 2", done, wr_cnt - wr_base);
        end
        checks++;
        if ({wr_addr[wr_base & 63], wr_data[wr_base & 63]} !== {8'h10, 32'h3322_1100}) begin
            errors++; $display("FAIL mac_lo: got %h %h expected 10 33221100", wr_addr[wr_base & 63], wr_data[wr_base & 63]);
        end
        checks++;
        if ({wr_addr[(wr_base + 1) & 63], wr_data[(wr_base + 1) & 63]} !== {8'h11, 32'h0000_5544}) begin
            errors++; $display("FAIL mac_hi: got %h %h expected 11 00005544", wr_addr[(wr_base + 1) & 63], wr_data[(wr_base + 1) & 63]);
        end
    endtask

    task automatic test_implicit_end();
        clear_tbl();
        for (int i = 0; i < N_ENTRY; i++) begin
            t_op[i] = 3'd1; t_addr[i] = 8'(i); t_data[i] = 32'(i * 3);
        end
        wr_base = wr_cnt;
        pulse_start();
        wait_end(200);
        checks++;
        if (done !== 1'b1 || wr_cnt - wr_base != 16) begin
            errors++; $display("FAIL full_table: got done=%b writes=%0d expected 1 16", done, wr_cnt - wr_base);
        end
        checks++;
        if ({wr_addr[(wr_cnt - 1) & 63], wr_data[(wr_cnt - 1) & 63]} !== {8'h0F, 32'd45}) begin
            errors++; $display("FAIL last_entry: got %h %h expected 0f 0000002d", wr_addr[(wr_cnt - 1) & 63], wr_data[(wr_cnt - 1) & 63]);
        end
    endtask

    task automatic test_end_codes();
        clear_tbl();
        t_op[0] = 3'd6;
        wr_base = wr_cnt; rd_base = rd_cnt;
        pulse_start();
        wait_end(20);
        checks++;
        if (done !== 1'b1 || wr_cnt != wr_base || rd_cnt != rd_base) begin
            errors++; $display("FAIL op6_end: got done=%b accesses=%0d expected 1 0", done, wr_cnt - wr_base + rd_cnt - rd_base);
        end
        t_op[0] = 3'd7;
        pulse_start();
        wait_end(20);
        checks++;
        if (done !== 1'b1 || wr_cnt != wr_base || rd_cnt != rd_base) begin
            errors++; $display("FAIL op7_end: got done=%b accesses=%0d expected 1 0", done, wr_cnt - wr_base + rd_cnt - rd_base);
        end
    endtask

    task automatic test_reset_mid_write();
        clear_tbl();
        t_op[0] = 3'd1; t_addr[0] = 8'h07; t_data[0] = 32'h1234_5678;
        waitrequest = 1'b1;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (write) break;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({write, busy, tbl_idx, address} !== 14'h0) begin
            errors++; $display("FAIL async_reset: got wr=%b busy=%b idx=%0d addr=%h expected 0 0 0 00", write, busy, tbl_idx, address);
        end
        waitrequest = 1'b0;
        wr_base = wr_cnt;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            if (c == 15) begin @(negedge clk) start = 1'b1; end
            if (c == 16) begin @(negedge clk) start = 1'b0; end
        end
        checks++;
        if ({write, address} !== {1'b1, 8'h07}) begin
            errors++; $display("FAIL rerun_c18: got wr=%b addr=%h expected 1 07", write, address);
        end
        wait_end(50);
        checks++;
        if ({done, err} !== 2'b10 || wr_cnt - wr_base != 1) begin
            errors++; $display("FAIL rerun_done: got done=%b err=%b writes=%0d expected 1 0 1", done, err, wr_cnt - wr_base);
        end
    endtask

    initial begin
        clear_tbl();
        test_reset();
        test_first_write();
        test_read_check();
        test_poll();
        test_timeout();
        test_mac();
        test_implicit_end();
        test_end_codes();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
